fifo_wr_arbiter: RTL and testbench

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

---
 rtl/fifo_wr_arbiter.sv | 173 +++++++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 454 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: two-producer write arbiter in front of a downstream FIFO.
// Producers are served in bursts of up to BURST words with round-robin
// hand-over between bursts. The module also tracks FIFO occupancy, gates
// consumer reads, and latches the FIFO overflow flag.
// Optional feature macro: FIFO_ARB_STATS_EN enables per-producer
// accepted-word counters on cnt_a/cnt_b. Without it they are tied to zero.
module fifo_wr_arbiter #(
    parameter int DW    = 8,
    parameter int DEPTH = 16,
    parameter int BURST = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_a,
    input  logic                   req_b,
    input  logic [DW-1:0]          data_a,
    input  logic [DW-1:0]          data_b,
    output logic                   gnt_a,
    output logic                   gnt_b,
    input  logic                   cons_rd,
    output logic                   rd_ack,
    output logic                   fifo_write,
    output logic [DW-1:0]          fifo_data,
    output logic                   fifo_read,
    input  logic                   fifo_overflow,
    output logic [$clog2(DEPTH):0] count,
    output logic                   err,
    output logic [15:0]            cnt_a,
    output logic [15:0]            cnt_b
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int BW = (BURST > 1) ? $clog2(BURST) : 1;
    localparam logic [BW-1:0] BEAT_LAST = BW'(BURST - 1);
    localparam logic [CW:0]   DEPTH_X   = (CW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        SERVE_A,
        SERVE_B
    } state_t;

    state_t        state;
    logic          last_b;
    logic [BW-1:0] beat;
    logic          space;
    logic          acc_a;
    logic          acc_b;

    // A word still sitting in the write register counts against capacity,
    // so the FIFO can never be offered more words than it can hold.
    assign space = ({1'b0, count} + {{CW{1'b0}}, fifo_write}) < DEPTH_X;

    assign gnt_a = !rst && (state == SERVE_A) && req_a && space;
    assign gnt_b = !rst && (state == SERVE_B) && req_b && space;
    assign acc_a = req_a && gnt_a;
    assign acc_b = req_b && gnt_b;

    // Reads only go out when something is stored; a word being written this
    // cycle is not yet in count, so it cannot be read back in the same cycle.
    assign rd_ack    = !rst && cons_rd && (count != '0);
    assign fifo_read = rd_ack;

    // Arbitration FSM: burst tenure per producer, round-robin on hand-over.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            last_b <= 1'b1;
            beat   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_a && (!req_b || last_b)) begin
                        state <= SERVE_A;
                    end else if (req_b) begin
                        state <= SERVE_B;
                    end
                end
                SERVE_A: begin
                    if ((acc_a && (beat == BEAT_LAST)) || !req_a) begin
                        last_b <= 1'b0;
                        beat   <= '0;
                        if (req_b) begin
                            state <= SERVE_B;
                        end else if (req_a) begin
                            state <= SERVE_A;
                        end else begin
                            state <= IDLE;
                        end
                    end else if (acc_a) begin
                        beat <= beat + 1'b1;
                    end
                end
                SERVE_B: begin
                    if ((acc_b && (beat == BEAT_LAST)) || !req_b) begin
                        last_b <= 1'b1;
                        beat   <= '0;
                        if (req_a) begin
                            state <= SERVE_A;
                        end else if (req_b) begin
                            state <= SERVE_B;
                        end else begin
                            state <= IDLE;
                        end
                    end else if (acc_b) begin
                        beat <= beat + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Write register: the accepted word reaches the FIFO one cycle later.
    always_ff @(posedge clk) begin
        if (rst) begin
            fifo_write <= 1'b0;
            fifo_data  <= '0;
        end else begin
            fifo_write <= acc_a || acc_b;
            if (acc_a) begin
                fifo_data <= data_a;
            end else if (acc_b) begin
                fifo_data <= data_b;
            end
        end
    end

    // Occupancy tracking: a simultaneous write and read cancel out.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else begin
            case ({fifo_write, fifo_read})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Sticky overflow flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            err <= 1'b0;
        end else if (fifo_overflow) begin
            err <= 1'b1;
        end
    end

`ifdef FIFO_ARB_STATS_EN
    // Saturating per-producer accept counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_a <= '0;
            cnt_b <= '0;
        end else begin
            if (acc_a && (cnt_a != 16'hFFFF)) begin
                cnt_a <= cnt_a + 1'b1;
            end
            if (acc_b && (cnt_b != 16'hFFFF)) begin
                cnt_b <= cnt_b + 1'b1;
            end
        end
    end
`else
    assign cnt_a = '0;
    assign cnt_b = '0;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Testbench for fifo_wr_arbiter (default parameters DW=8, DEPTH=16, BURST=4).
// Expected words are queued when an accept is expected and popped by a
// monitor when the DUT raises fifo_write. Works with or without
// FIFO_ARB_STATS_EN defined.
module tb_fifo_wr_arbiter;

    logic       clk;
    logic       rst;
    logic       req_a;
    logic       req_b;
    logic [7:0] data_a;
    logic [7:0] data_b;
    logic       gnt_a;
    logic       gnt_b;
    logic       cons_rd;
    logic       rd_ack;
    logic       fifo_write;
    logic [7:0] fifo_data;
    logic       fifo_read;
    logic       fifo_overflow;
    logic [4:0] count;
    logic       err;
    logic [15:0] cnt_a;
    logic [15:0] cnt_b;

    int         errors = 0;
    int         checks = 0;
    logic       mon_en = 1'b0;
    logic [7:0] exp_q[$];

    fifo_wr_arbiter #(.DW(8), .DEPTH(16), .BURST(4)) dut (
        .clk(clk),
        .rst(rst),
        .req_a(req_a),
        .req_b(req_b),
        .data_a(data_a),
        .data_b(data_b),
        .gnt_a(gnt_a),
        .gnt_b(gnt_b),
        .cons_rd(cons_rd),
        .rd_ack(rd_ack),
        .fifo_write(fifo_write),
        .fifo_data(fifo_data),
        .fifo_read(fifo_read),
        .fifo_overflow(fifo_overflow),
        .count(count),
        .err(err),
        .cnt_a(cnt_a),
        .cnt_b(cnt_b)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard monitor: a write must appear exactly one cycle after each
    // expected accept, carrying the queued word.
    always @(posedge clk) begin
        logic [7:0] e;
        #2;
        if (mon_en) begin
            checks++;
            if (fifo_write !== (exp_q.size() != 0)) begin
                errors++;
                $display("[TB] FAIL wr_strobe t=%0t: fifo_write=%b expected %b", $time, fifo_write, exp_q.size() != 0);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                checks++;
                if (fifo_data !== e) begin
                    errors++;
                    $display("[TB] FAIL wr_data t=%0t: fifo_data=%h expected %h", $time, fifo_data, e);
                end
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        req_a         = 1'b0;
        req_b         = 1'b0;
        cons_rd       = 1'b0;
        fifo_overflow = 1'b0;
        next_cycle();
        next_cycle();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst           = 1'b1;
        req_a         = 1'b1;
        req_b         = 1'b1;
        cons_rd       = 1'b1;
        fifo_overflow = 1'b0;
        data_a        = 8'h00;
        data_b        = 8'h00;
        next_cycle();
        next_cycle();
        #3;
        checks++;
        if ({gnt_a, gnt_b, rd_ack, fifo_read} !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL reset_comb: gnt_a/gnt_b/rd_ack/fifo_read=%b expected 0000", {gnt_a, gnt_b, rd_ack, fifo_read});
        end
        checks++;
        if (fifo_write !== 1'b0 || fifo_data !== 8'h00 || count !== 5'd0 || err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_regs: wr=%b data=%h count=%0d err=%b expected 0 00 0 0", fifo_write, fifo_data, count, err);
        end
        checks++;
        if (cnt_a !== 16'd0 || cnt_b !== 16'd0) begin
            errors++;
            $display("[TB] FAIL reset_stats: cnt_a=%0d cnt_b=%0d expected 0 0", cnt_a, cnt_b);
        end
        next_cycle();
        rst     = 1'b0;
        req_a   = 1'b0;
        req_b   = 1'b0;
        cons_rd = 1'b0;
        mon_en  = 1'b1;
        next_cycle();
        fifo_overflow = 1'b1;
        next_cycle();
        fifo_overflow = 1'b0;
        next_cycle();
        next_cycle();
        #3;
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("[TB] FAIL err_sticky: err=%b expected 1", err);
        end
        next_cycle();
        do_reset();
        #3;
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL err_clear: err=%b expected 0", err);
        end
        next_cycle();
    endtask

    task automatic test_single();
        logic [7:0]  d;
        logic        exp_g;
        logic [15:0] exp_cnt;
        do_reset();
        d = 8'hE0;
        for (int c = 0; c < 7; c++) begin
            req_a  = 1'b1;
            data_a = d;
            #3;
            exp_g = (c != 0);
            checks++;
            if (gnt_a !== exp_g || gnt_b !== 1'b0) begin
                errors++;
                $display("[TB] FAIL single_gnt cyc%0d: gnt_a=%b gnt_b=%b expected %b 0", c, gnt_a, gnt_b, exp_g);
            end
            if (exp_g) begin
                exp_q.push_back(d);
                d = d + 8'd1;
            end
            next_cycle();
        end
        req_a = 1'b0;
        next_cycle();
        next_cycle();
        #3;
        checks++;
        if (count !== 5'd6) begin
            errors++;
            $display("[TB] FAIL single_count: count=%0d expected 6", count);
        end
`ifdef FIFO_ARB_STATS_EN
        exp_cnt = 16'd6;
`else
        exp_cnt = 16'd0;
`endif
        checks++;
        if (cnt_a !== exp_cnt) begin
            errors++;
            $display("[TB] FAIL single_cnt_a: cnt_a=%0d expected %0d", cnt_a, exp_cnt);
        end
        next_cycle();
    endtask

    task automatic test_alternate();
        logic [7:0]  da;
        logic [7:0]  db;
        logic        ea;
        logic        eb;
        logic [15:0] exp_ca;
        logic [15:0] exp_cb;
        do_reset();
        da = 8'hA0;
        db = 8'hB0;
        for (int c = 0; c < 13; c++) begin
            req_a  = 1'b1;
            req_b  = 1'b1;
            data_a = da;
            data_b = db;
            #3;
            ea = (c >= 1 && c <= 4) || (c >= 9 && c <= 12);
            eb = (c >= 5 && c <= 8);
            checks++;
            if (gnt_a !== ea || gnt_b !== eb) begin
                errors++;
                $display("[TB] FAIL alt_gnt cyc%0d: gnt_a=%b gnt_b=%b expected %b %b", c, gnt_a, gnt_b, ea, eb);
            end
            if (ea) begin
                exp_q.push_back(da);
                da = da + 8'd1;
            end
            if (eb) begin
                exp_q.push_back(db);
                db = db + 8'd1;
            end
            next_cycle();
        end
        req_a = 1'b0;
        req_b = 1'b0;
        next_cycle();
        next_cycle();
        #3;
        checks++;
        if (count !== 5'd12) begin
            errors++;
            $display("[TB] FAIL alt_count: count=%0d expected 12", count);
        end
`ifdef FIFO_ARB_STATS_EN
        exp_ca = 16'd8;
        exp_cb = 16'd4;
`else
        exp_ca = 16'd0;
        exp_cb = 16'd0;
`endif
        checks++;
        if (cnt_a !== exp_ca || cnt_b !== exp_cb) begin
            errors++;
            $display("[TB] FAIL alt_stats: cnt_a=%0d cnt_b=%0d expected %0d %0d", cnt_a, cnt_b, exp_ca, exp_cb);
        end
        next_cycle();
    endtask

    task automatic test_full_and_drain_one();
        logic [7:0] d;
        logic       exp_g;
        do_reset();
        d = 8'h10;
        for (int c = 0; c < 21; c++) begin
            req_a  = 1'b1;
            data_a = d;
            #3;
            exp_g = (c >= 1 && c <= 16);
            checks++;
            if (gnt_a !== exp_g) begin
                errors++;
                $display("[TB] FAIL full_gnt cyc%0d: gnt_a=%b expected %b", c, gnt_a, exp_g);
            end
            if (exp_g) begin
                exp_q.push_back(d);
                d = d + 8'd1;
            end
            next_cycle();
        end
        #3;
        checks++;
        if (count !== 5'd16 || err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL full_count: count=%0d err=%b expected 16 0", count, err);
        end
        next_cycle();
        cons_rd = 1'b1;
        #3;
        checks++;
        if (rd_ack !== 1'b1 || fifo_read !== 1'b1 || gnt_a !== 1'b0) begin
            errors++;
            $display("[TB] FAIL drain_rd: rd_ack=%b fifo_read=%b gnt_a=%b expected 1 1 0", rd_ack, fifo_read, gnt_a);
        end
        next_cycle();
        cons_rd = 1'b0;
        data_a  = d;
        #3;
        checks++;
        if (count !== 5'd15 || gnt_a !== 1'b1) begin
            errors++;
            $display("[TB] FAIL drain_accept: count=%0d gnt_a=%b expected 15 1", count, gnt_a);
        end
        exp_q.push_back(d);
        d = d + 8'd1;
        next_cycle();
        data_a = d;
        #3;
        checks++;
        if (gnt_a !== 1'b0) begin
            errors++;
            $display("[TB] FAIL drain_block: gnt_a=%b expected 0", gnt_a);
        end
        next_cycle();
        next_cycle();
        #3;
        checks++;
        if (count !== 5'd16 || err !== 1'b0 || gnt_a !== 1'b0) begin
            errors++;
            $display("[TB] FAIL drain_refill: count=%0d err=%b gnt_a=%b expected 16 0 0", count, err, gnt_a);
        end
        req_a = 1'b0;
        next_cycle();
    endtask

    task automatic test_empty_read();
        logic [7:0] d;
        logic       exp_g;
        do_reset();
        cons_rd = 1'b1;
        #3;
        checks++;
        if (rd_ack !== 1'b0 || fifo_read !== 1'b0) begin
            errors++;
            $display("[TB] FAIL empty_rd: rd_ack=%b fifo_read=%b expected 0 0", rd_ack, fifo_read);
        end
        next_cycle();
        cons_rd = 1'b0;
        d = 8'h50;
        for (int c = 0; c < 6; c++) begin
            req_a  = 1'b1;
            data_a = d;
            #3;
            exp_g = (c != 0);
            checks++;
            if (gnt_a !== exp_g) begin
                errors++;
                $display("[TB] FAIL fill5_gnt cyc%0d: gnt_a=%b expected %b", c, gnt_a, exp_g);
            end
            if (exp_g) begin
                exp_q.push_back(d);
                d = d + 8'd1;
            end
            next_cycle();
        end
        req_a = 1'b0;
        next_cycle();
        next_cycle();
        for (int c = 0; c < 2; c++) begin
            req_a  = 1'b1;
            data_a = 8'h77;
            #3;
            exp_g = (c == 1);
            checks++;
            if (gnt_a !== exp_g) begin
                errors++;
                $display("[TB] FAIL rw_gnt cyc%0d: gnt_a=%b expected %b", c, gnt_a, exp_g);
            end
            if (exp_g) exp_q.push_back(8'h77);
            next_cycle();
        end
        req_a   = 1'b0;
        cons_rd = 1'b1;
        #3;
        checks++;
        if (count !== 5'd5 || rd_ack !== 1'b1) begin
            errors++;
            $display("[TB] FAIL rw_same: count=%0d rd_ack=%b expected 5 1", count, rd_ack);
        end
        next_cycle();
        cons_rd = 1'b0;
        #3;
        checks++;
        if (count !== 5'd5) begin
            errors++;
            $display("[TB] FAIL rw_count: count=%0d expected 5", count);
        end
        next_cycle();
    endtask

    task automatic test_reset_mid_burst();
        logic [7:0]  d;
        logic        exp_g;
        logic [15:0] exp_cnt;
        do_reset();
        d = 8'hC0;
        for (int c = 0; c < 4; c++) begin
            req_a  = 1'b1;
            data_a = d;
            #3;
            exp_g = (c != 0);
            checks++;
            if (gnt_a !== exp_g) begin
                errors++;
                $display("[TB] FAIL mid_gnt cyc%0d: gnt_a=%b expected %b", c, gnt_a, exp_g);
            end
            if (exp_g) begin
                exp_q.push_back(d);
                d = d + 8'd1;
            end
            next_cycle();
        end
        rst = 1'b1;
        #3;
`ifdef FIFO_ARB_STATS_EN
        exp_cnt = 16'd3;
`else
        exp_cnt = 16'd0;
`endif
        checks++;
        if (gnt_a !== 1'b0 || count !== 5'd2 || cnt_a !== exp_cnt) begin
            errors++;
            $display("[TB] FAIL mid_rst_cycle: gnt_a=%b count=%0d cnt_a=%0d expected 0 2 %0d", gnt_a, count, cnt_a, exp_cnt);
        end
        next_cycle();
        rst   = 1'b0;
        req_a = 1'b0;
        #3;
        checks++;
        if (fifo_write !== 1'b0 || count !== 5'd0 || cnt_a !== 16'd0 || err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mid_after: wr=%b count=%0d cnt_a=%0d err=%b expected 0 0 0 0", fifo_write, count, cnt_a, err);
        end
        next_cycle();
        next_cycle();
    endtask

    // Test sequence.
    initial begin
        rst           = 1'b1;
        req_a         = 1'b0;
        req_b         = 1'b0;
        data_a        = 8'h00;
        data_b        = 8'h00;
        cons_rd       = 1'b0;
        fifo_overflow = 1'b0;
        next_cycle();
        test_reset();
        test_single();
        test_alternate();
        test_full_and_drain_one();
        test_empty_read();
        test_reset_mid_burst();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL leftover: %0d queued words never written, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
